// File: rtl/bus_pkg.sv
// Shared types and width helpers for the data bus router and its timeout counter.
package bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } bus_state_e;

    // Wide enough for the largest supported TIMEOUT (255).
    localparam int CTR_W = 8;

    function automatic int sel_width(input int num_slv);
        return (num_slv > 1) ? $clog2(num_slv) : 1;
    endfunction

    function automatic int be_width(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/bus_timeout_ctr.sv
// Counts ACCESS cycles without a slave response; hit flags the cycle that exhausts the budget.
module bus_timeout_ctr
    import bus_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic hit
);

    logic [CTR_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CTR_W'(1);
        end
    end

    // The TIMEOUT-th waiting cycle is the one that sees cnt == TIMEOUT-1.
    assign hit = en && (cnt == CTR_W'(TIMEOUT - 1));

endmodule

// File: rtl/data_bus_router.sv
// Single-master to NUM_SLV-slave bus router: decodes the slot from the top address bits,
// drives one slave at a time and returns a one-cycle completion with data or bus error.
module data_bus_router
    import bus_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 32,
    parameter int NUM_SLV = 2,
    parameter int TIMEOUT = 15
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      m_req,
    input  logic                      m_write,
    input  logic [ADDR_W-1:0]         m_addr,
    input  logic [DATA_W-1:0]         m_wdata,
    input  logic [DATA_W/8-1:0]       m_width,
    output logic                      m_ready,
    output logic [DATA_W-1:0]         m_rdata,
    output logic                      m_err,
    output logic [NUM_SLV-1:0]        s_req,
    output logic                      s_write,
    output logic [ADDR_W-1:0]         s_addr,
    output logic [DATA_W-1:0]         s_wdata,
    output logic [DATA_W/8-1:0]       s_width,
    input  logic [NUM_SLV-1:0]        s_ready,
    input  logic [NUM_SLV*DATA_W-1:0] s_rdata
);

    localparam int SEL_W = sel_width(NUM_SLV);
    localparam int BE_W  = be_width(DATA_W);

    bus_state_e        state, state_nxt;
    logic [SEL_W-1:0]  slot_in, slot_q;
    logic              slot_ok, accept;
    logic              sel_ready;
    logic [DATA_W-1:0] sel_rdata;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;
    logic              to_clr, to_en, to_hit;

    assign slot_in = m_addr[ADDR_W-1 -: SEL_W];
    assign slot_ok = 32'(slot_in) < 32'(NUM_SLV);
    assign accept  = (state == ST_IDLE) && m_req;

    // Only the addressed slave's ready and data are looked at.
    always_comb begin
        sel_ready = 1'b0;
        sel_rdata = '0;
        for (int k = 0; k < NUM_SLV; k++) begin
            if (slot_q == SEL_W'(k)) begin
                sel_ready = s_ready[k];
                sel_rdata = s_rdata[k*DATA_W +: DATA_W];
            end
        end
    end

    assign to_clr = accept && slot_ok;
    assign to_en  = (state == ST_ACCESS) && !sel_ready;

    bus_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (to_clr),
        .en    (to_en),
        .hit   (to_hit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (m_req) state_nxt = slot_ok ? ST_ACCESS : ST_RESP;
            ST_ACCESS: if (sel_ready || to_hit) state_nxt = ST_RESP;
            ST_RESP:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Request registers double as the slave-side bus, so they stay stable through ACCESS.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_write <= 1'b0;
            s_addr  <= '0;
            s_wdata <= '0;
            s_width <= '0;
            slot_q  <= '0;
        end else if (accept) begin
            s_write <= m_write;
            s_addr  <= m_addr;
            s_wdata <= m_wdata;
            s_width <= BE_W'(m_width);
            slot_q  <= slot_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else if (accept && !slot_ok) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
        end else if (state == ST_ACCESS) begin
            // Ready beats a coincident timeout.
            if (sel_ready) begin
                rdata_q <= s_write ? '0 : sel_rdata;
                err_q   <= 1'b0;
            end else if (to_hit) begin
                rdata_q <= '0;
                err_q   <= 1'b1;
            end
        end
    end

    always_comb begin
        s_req = '0;
        if (state == ST_ACCESS) begin
            for (int k = 0; k < NUM_SLV; k++) begin
                s_req[k] = (slot_q == SEL_W'(k));
            end
        end
    end

    assign m_ready = (state == ST_RESP);
    assign m_err   = m_ready && err_q;
    assign m_rdata = m_ready ? rdata_q : '0;

endmodule

// File: tb/tb_data_bus_router.sv
// Bench for data_bus_router (3 slaves, TIMEOUT=4): directed scenarios plus random traffic,
// all compared every cycle against a transaction-level reference model.
module tb_data_bus_router;

    localparam int ADDR_W  = 10;
    localparam int DATA_W  = 32;
    localparam int NUM_SLV = 3;
    localparam int TIMEOUT = 4;

    logic                      clk = 1'b0;
    logic                      rst_n = 1'b0;
    logic                      m_req = 1'b0;
    logic                      m_write = 1'b0;
    logic [ADDR_W-1:0]         m_addr = '0;
    logic [DATA_W-1:0]         m_wdata = '0;
    logic [3:0]                m_width = '0;
    logic                      m_ready;
    logic [DATA_W-1:0]         m_rdata;
    logic                      m_err;
    logic [NUM_SLV-1:0]        s_req;
    logic                      s_write;
    logic [ADDR_W-1:0]         s_addr;
    logic [DATA_W-1:0]         s_wdata;
    logic [3:0]                s_width;
    logic [NUM_SLV-1:0]        s_ready = '0;
    logic [NUM_SLV*DATA_W-1:0] s_rdata = '0;

    int checks = 0;
    int errors = 0;

    data_bus_router #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .NUM_SLV (NUM_SLV),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .m_req   (m_req),
        .m_write (m_write),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_width (m_width),
        .m_ready (m_ready),
        .m_rdata (m_rdata),
        .m_err   (m_err),
        .s_req   (s_req),
        .s_write (s_write),
        .s_addr  (s_addr),
        .s_wdata (s_wdata),
        .s_width (s_width),
        .s_ready (s_ready),
        .s_rdata (s_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference model: one transaction in flight at most; tracks how many cycles it has waited.
    bit              mb_busy = 0;
    bit              mb_resp = 0;
    int              mb_slot = 0;
    int              mb_waited = 0;
    logic            mb_write = 0;
    logic [9:0]      mb_addr = '0;
    logic [31:0]     mb_wdata = '0;
    logic [3:0]      mb_width = '0;
    logic [31:0]     mb_rdata = '0;
    logic            mb_err = 0;

    task automatic model_clear();
        mb_busy = 0; mb_resp = 0; mb_slot = 0; mb_waited = 0;
        mb_write = 0; mb_addr = '0; mb_wdata = '0; mb_width = '0;
        mb_rdata = '0; mb_err = 0;
    endtask

    always @(posedge clk) begin
        if (!rst_n) begin
            model_clear();
        end else if (mb_resp) begin
            mb_resp = 0;
        end else if (mb_busy) begin
            if (s_ready[mb_slot]) begin
                mb_rdata = mb_write ? 32'd0 : s_rdata[mb_slot*32 +: 32];
                mb_err   = 0;
                mb_busy  = 0;
                mb_resp  = 1;
            end else begin
                mb_waited++;
                if (mb_waited >= TIMEOUT) begin
                    mb_rdata = 32'd0;
                    mb_err   = 1;
                    mb_busy  = 0;
                    mb_resp  = 1;
                end
            end
        end else if (m_req) begin
            mb_write = m_write; mb_addr = m_addr; mb_wdata = m_wdata; mb_width = m_width;
            mb_slot  = int'(m_addr[9:8]);
            if (mb_slot < NUM_SLV) begin
                mb_busy   = 1;
                mb_waited = 0;
            end else begin
                mb_resp  = 1;
                mb_err   = 1;
                mb_rdata = 32'd0;
            end
        end
    end

    always @(negedge clk) begin
        logic [2:0] e_sreq;
        e_sreq = mb_busy ? 3'(1 << mb_slot) : 3'b000;
        check("mdl_m_ready", 64'(m_ready), 64'(mb_resp));
        check("mdl_m_err",   64'(m_err),   64'(mb_resp ? mb_err : 1'b0));
        check("mdl_m_rdata", 64'(m_rdata), 64'(mb_resp ? mb_rdata : 32'd0));
        check("mdl_s_req",   64'(s_req),   64'(e_sreq));
        check("mdl_s_write", 64'(s_write), 64'(mb_write));
        check("mdl_s_addr",  64'(s_addr),  64'(mb_addr));
        check("mdl_s_wdata", 64'(s_wdata), 64'(mb_wdata));
        check("mdl_s_width", 64'(s_width), 64'(mb_width));
    end

    task automatic put_req(input logic wr, input logic [9:0] addr, input logic [31:0] wd,
                           input logic [3:0] be);
        m_req = 1'b1; m_write = wr; m_addr = addr; m_wdata = wd; m_width = be;
    endtask

    task automatic timeout_case(input bit ready_on_4th, input logic [31:0] exp_rd,
                                input logic exp_err);
        s_ready = 3'b101;
        s_rdata = {32'h77777777, 32'h55AA55AA, 32'h33333333};
        put_req(1'b0, 10'h100, 32'h0, 4'hF);
        for (int i = 1; i <= TIMEOUT; i++) begin
            @(negedge clk);
            if (i == 1) m_req = 1'b0;
            check("to_s_req", 64'(s_req), 64'h2);
            check("to_busy_no_ready", 64'(m_ready), 64'd0);
            if (ready_on_4th && i == TIMEOUT) s_ready = 3'b010;
        end
        @(negedge clk);
        check("to_m_ready", 64'(m_ready), 64'd1);
        check("to_m_err",   64'(m_err),   64'(exp_err));
        check("to_m_rdata", 64'(m_rdata), 64'(exp_rd));
        s_ready = 3'b000;
        @(negedge clk);
    endtask

    initial begin
        int pulses;
        int last_pulse;

        // Reset state
        @(negedge clk);
        check("rst_m_ready", 64'(m_ready), 64'd0);
        check("rst_s_req",   64'(s_req),   64'd0);
        check("rst_s_addr",  64'(s_addr),  64'd0);
        check("rst_m_rdata", 64'(m_rdata), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Read slot 1, ready on first ACCESS cycle
        s_ready = 3'b010;
        s_rdata = {32'h11111111, 32'hDEADBEEF, 32'h22222222};
        put_req(1'b0, 10'h104, 32'h0, 4'hF);
        @(negedge clk);
        m_req = 1'b0;
        check("rd_s_req", 64'(s_req), 64'h2);
        check("rd_early", 64'(m_ready), 64'd0);
        @(negedge clk);
        check("rd_m_ready", 64'(m_ready), 64'd1);
        check("rd_m_rdata", 64'(m_rdata), 64'hDEADBEEF);
        check("rd_m_err",   64'(m_err),   64'd0);
        check("rd_s_req_resp", 64'(s_req), 64'd0);
        s_ready = 3'b000;
        @(negedge clk);
        check("rd_pulse_one", 64'(m_ready), 64'd0);

        // Write slot 0, slave ready on third ACCESS cycle
        s_rdata = {32'h0, 32'h0, 32'hCAFEF00D};
        put_req(1'b1, 10'h010, 32'h12345678, 4'b0011);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            if (i == 1) m_req = 1'b0;
            m_wdata = 32'hFFFFFFFF;
            check("wr_s_req",   64'(s_req),   64'h1);
            check("wr_s_addr",  64'(s_addr),  64'h010);
            check("wr_s_wdata", 64'(s_wdata), 64'h12345678);
            check("wr_s_width", 64'(s_width), 64'h3);
            check("wr_s_write", 64'(s_write), 64'd1);
            if (i == 3) s_ready = 3'b001;
        end
        @(negedge clk);
        check("wr_m_ready", 64'(m_ready), 64'd1);
        check("wr_m_rdata", 64'(m_rdata), 64'd0);
        check("wr_m_err",   64'(m_err),   64'd0);
        s_ready = 3'b000;
        @(negedge clk);

        // Slot 3 does not exist
        s_ready = 3'b111;
        put_req(1'b0, 10'h3FC, 32'h0, 4'hF);
        @(negedge clk);
        m_req = 1'b0;
        check("bad_s_req",   64'(s_req),   64'd0);
        check("bad_m_ready", 64'(m_ready), 64'd1);
        check("bad_m_err",   64'(m_err),   64'd1);
        check("bad_m_rdata", 64'(m_rdata), 64'd0);
        @(negedge clk);
        check("bad_pulse_one", 64'(m_ready), 64'd0);
        s_ready = 3'b000;

        // Timeout, then ready coinciding with the timeout cycle
        timeout_case(1'b0, 32'h0, 1'b0 | 1'b1);
        timeout_case(1'b1, 32'h55AA55AA, 1'b0);

        // Reset while in ACCESS
        s_rdata = {32'h0, 32'h0, 32'h0BADF00D};
        put_req(1'b0, 10'h020, 32'h0, 4'hF);
        @(negedge clk);
        m_req = 1'b0;
        @(negedge clk);
        check("rst_mid_busy", 64'(s_req), 64'h1);
        #2 rst_n = 1'b0;
        model_clear();
        #1;
        check("rst_async_s_req",  64'(s_req),  64'd0);
        check("rst_async_s_addr", 64'(s_addr), 64'd0);
        @(negedge clk);
        check("rst_no_m_ready", 64'(m_ready), 64'd0);
        rst_n = 1'b1;
        s_ready = 3'b001;
        put_req(1'b0, 10'h020, 32'h0, 4'hF);
        @(negedge clk);
        m_req = 1'b0;
        check("post_rst_s_req", 64'(s_req), 64'h1);
        @(negedge clk);
        check("post_rst_m_ready", 64'(m_ready), 64'd1);
        check("post_rst_m_rdata", 64'(m_rdata), 64'h0BADF00D);
        s_ready = 3'b000;
        @(negedge clk);

        // Four back-to-back reads with m_req held high
        pulses = 0;
        last_pulse = -1;
        s_rdata = {32'hAAAA0002, 32'hBBBB0001, 32'hCCCC0000};
        s_ready = 3'b010;
        put_req(1'b0, 10'h1F0, 32'h0, 4'hF);
        for (int i = 1; i <= 15; i++) begin
            @(negedge clk);
            if (m_ready) begin
                if (last_pulse >= 0) check("b2b_spacing", 64'(i - last_pulse), 64'd3);
                check("b2b_rdata", 64'(m_rdata), 64'hBBBB0001);
                last_pulse = i;
                pulses++;
            end
            if (i == 10) m_req = 1'b0;
            s_ready = {1'($urandom), 1'b1, 1'($urandom)};
        end
        check("b2b_pulses", 64'(pulses), 64'd4);
        s_ready = 3'b000;

        // Random traffic, checked against the model every cycle
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            m_req   = ($urandom_range(0, 1) == 1);
            m_write = 1'($urandom);
            m_addr  = 10'($urandom);
            m_wdata = $urandom;
            m_width = 4'($urandom);
            for (int k = 0; k < NUM_SLV; k++) s_ready[k] = ($urandom_range(0, 9) < 3);
            s_rdata = {$urandom, $urandom, $urandom};
            if ($urandom_range(0, 99) == 0) begin
                #2 rst_n = 1'b0;
                model_clear();
                @(negedge clk);
                rst_n = 1'b1;
            end
        end

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule
